// File: rtl/dual_port_mem_pkg.sv
// Shared constants, max-width types and the byte-strobe merge helper for dual_port_mem.
package dual_port_mem_pkg;
  localparam int BYTE_W     = 8;
  localparam int MAX_CELL_W = 256;
  localparam int MAX_STRB_W = MAX_CELL_W / BYTE_W;

  typedef logic [MAX_CELL_W-1:0] cell_max_t;
  typedef logic [MAX_STRB_W-1:0] strb_max_t;

  // Callers zero-extend narrower cells; bytes above the real cell width carry no strobe.
  function automatic cell_max_t strb_merge(input cell_max_t old_v,
                                           input cell_max_t new_v,
                                           input strb_max_t strb);
    cell_max_t res;
    res = old_v;
    for (int k = 0; k < MAX_STRB_W; k++) begin
      if (strb[k]) res[k*BYTE_W +: BYTE_W] = new_v[k*BYTE_W +: BYTE_W];
    end
    return res;
  endfunction
endpackage

// File: rtl/dual_port_mem_array.sv
// Storage for dual_port_mem: byte-strobed synchronous write, asynchronous read.
module dual_port_mem_array
  import dual_port_mem_pkg::*;
#(
  parameter  int CELL_WIDTH = 32,
  parameter  int ADDR_WIDTH = 8,
  localparam int STRB_WIDTH = CELL_WIDTH / BYTE_W
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [CELL_WIDTH-1:0] wdata_i,
  input  logic [STRB_WIDTH-1:0] wstrb_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [CELL_WIDTH-1:0] rdata_o
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [CELL_WIDTH-1:0] r_mem [DEPTH];

  // Contents are never reset; writes are only suppressed while reset is held.
  always_ff @(posedge clk_i) begin
    if (we_i && !arst_i) begin
      for (int k = 0; k < STRB_WIDTH; k++) begin
        if (wstrb_i[k]) r_mem[waddr_i][k*BYTE_W +: BYTE_W] <= wdata_i[k*BYTE_W +: BYTE_W];
      end
    end
  end

  assign rdata_o = r_mem[raddr_i];
endmodule

// File: rtl/dual_port_mem.sv
// Dual-port memory: strobed write port plus valid/ready read port with a registered response.
// Define DUAL_PORT_MEM_BYPASS_EN for write-first collisions; default is read-first.
module dual_port_mem
  import dual_port_mem_pkg::*;
#(
  parameter  int CELL_WIDTH = 32,
  parameter  int ADDR_WIDTH = 8,
  localparam int STRB_WIDTH = CELL_WIDTH / BYTE_W
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [CELL_WIDTH-1:0] wdata_i,
  input  logic [STRB_WIDTH-1:0] wstrb_i,
  input  logic                  rreq_valid_i,
  output logic                  rreq_ready_o,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [CELL_WIDTH-1:0] rsp_data_o
);
  logic [CELL_WIDTH-1:0] w_rdata;
  logic [CELL_WIDTH-1:0] w_rsp_next;
  logic                  w_accept;
  logic                  r_rsp_valid;
  logic [CELL_WIDTH-1:0] r_rsp_data;

  dual_port_mem_array #(
    .CELL_WIDTH (CELL_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk_i   (clk_i),
    .arst_i  (arst_i),
    .we_i    (we_i),
    .waddr_i (waddr_i),
    .wdata_i (wdata_i),
    .wstrb_i (wstrb_i),
    .raddr_i (raddr_i),
    .rdata_o (w_rdata)
  );

  assign rreq_ready_o = !r_rsp_valid || rsp_ready_i;
  assign w_accept     = rreq_valid_i && rreq_ready_o;

  always_comb begin
    w_rsp_next = w_rdata;
`ifdef DUAL_PORT_MEM_BYPASS_EN
    if (we_i && (waddr_i == raddr_i)) begin
      w_rsp_next = CELL_WIDTH'(strb_merge(cell_max_t'(w_rdata), cell_max_t'(wdata_i),
                                          strb_max_t'(wstrb_i)));
    end
`endif
  end

  // Response stage: loads only on acceptance, otherwise holds data and drops valid once consumed.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_rsp_next;
    end else if (rsp_ready_i) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid_o = r_rsp_valid;
  assign rsp_data_o  = r_rsp_data;
endmodule

// File: tb/tb_dual_port_mem.sv
// Directed plus randomized bench for dual_port_mem against a cycle-level behavioural model.
module tb_dual_port_mem;
  localparam int CW = 32;
  localparam int AW = 8;
  localparam int SW = CW / 8;

  logic          clk_i = 1'b0;
  logic          arst_i;
  logic          we_i;
  logic [AW-1:0] waddr_i;
  logic [CW-1:0] wdata_i;
  logic [SW-1:0] wstrb_i;
  logic          rreq_valid_i;
  logic          rreq_ready_o;
  logic [AW-1:0] raddr_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [CW-1:0] rsp_data_o;

  int checks = 0;
  int errors = 0;

  logic [CW-1:0] ref_mem [2**AW];
  logic          m_valid;
  logic [CW-1:0] m_data;

  always #5 clk_i = ~clk_i;

  dual_port_mem #(.CELL_WIDTH(CW), .ADDR_WIDTH(AW)) dut (
    .clk_i        (clk_i),
    .arst_i       (arst_i),
    .we_i         (we_i),
    .waddr_i      (waddr_i),
    .wdata_i      (wdata_i),
    .wstrb_i      (wstrb_i),
    .rreq_valid_i (rreq_valid_i),
    .rreq_ready_o (rreq_ready_o),
    .raddr_i      (raddr_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_data_o   (rsp_data_o)
  );

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock: update the model from the inputs seen at the edge, then compare.
  task automatic tick();
    logic          acc;
    logic [CW-1:0] nxt;
    if (arst_i) begin
      m_valid = 1'b0;
      m_data  = '0;
    end else begin
      acc = rreq_valid_i && (!m_valid || rsp_ready_i);
      if (acc) begin
        nxt = ref_mem[raddr_i];
`ifdef DUAL_PORT_MEM_BYPASS_EN
        if (we_i && waddr_i == raddr_i)
          for (int k = 0; k < SW; k++) if (wstrb_i[k]) nxt[8*k +: 8] = wdata_i[8*k +: 8];
`endif
        m_valid = 1'b1;
        m_data  = nxt;
      end else if (rsp_ready_i) begin
        m_valid = 1'b0;
      end
      if (we_i)
        for (int k = 0; k < SW; k++)
          if (wstrb_i[k]) ref_mem[waddr_i][8*k +: 8] = wdata_i[8*k +: 8];
    end
    @(posedge clk_i);
    #1;
    check("rsp_valid", CW'(rsp_valid_o), CW'(m_valid));
    check("rsp_data", rsp_data_o, m_data);
    check("rreq_ready", CW'(rreq_ready_o), CW'(!m_valid || rsp_ready_i));
    @(negedge clk_i);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [CW-1:0] d, input logic [SW-1:0] s);
    we_i = 1'b1; waddr_i = a; wdata_i = d; wstrb_i = s;
    rreq_valid_i = 1'b0; rsp_ready_i = 1'b1;
    tick();
    we_i = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    we_i = 1'b0; rreq_valid_i = 1'b1; raddr_i = a; rsp_ready_i = 1'b1;
    tick();
    rreq_valid_i = 1'b0;
  endtask

  initial begin
    arst_i = 1'b1; we_i = 1'b0; waddr_i = '0; wdata_i = '0; wstrb_i = '0;
    rreq_valid_i = 1'b0; raddr_i = '0; rsp_ready_i = 1'b0;
    m_valid = 1'b0; m_data = '0;
    #1;
    check("reset_valid", CW'(rsp_valid_o), 0);
    check("reset_data", rsp_data_o, 0);
    @(negedge clk_i);
    tick();
    arst_i = 1'b0;
    check("ready_after_reset", CW'(rreq_ready_o), 1);

    // Strobed write and merge
    wr(8'd5, 32'h11223344, 4'b1111);
    wr(8'd5, 32'hAABBCCDD, 4'b0101);
    rd(8'd5);
    check("strobe_merge", rsp_data_o, 32'h11BB33DD);
    check("strobe_latency_valid", CW'(rsp_valid_o), 1);

    // Backpressure with a concurrent write to the pending address
    rsp_ready_i = 1'b1; tick();
    rreq_valid_i = 1'b1; raddr_i = 8'd5; rsp_ready_i = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      we_i = (i == 0); waddr_i = 8'd5; wdata_i = '0; wstrb_i = 4'hF;
      raddr_i = 8'(i + 20);
      tick();
      check("bp_hold_data", rsp_data_o, 32'h11BB33DD);
      check("bp_ready_low", CW'(rreq_ready_o), 0);
    end
    we_i = 1'b0; rreq_valid_i = 1'b0; rsp_ready_i = 1'b1;
    tick();
    check("bp_consumed", CW'(rsp_valid_o), 0);
    check("bp_data_retained", rsp_data_o, 32'h11BB33DD);

    // Read/write collision
    wr(8'd9, 32'hFFFFFFFF, 4'hF);
    we_i = 1'b1; waddr_i = 8'd9; wdata_i = '0; wstrb_i = 4'b0011;
    rreq_valid_i = 1'b1; raddr_i = 8'd9; rsp_ready_i = 1'b1;
    tick();
`ifdef DUAL_PORT_MEM_BYPASS_EN
    check("collision_bypass", rsp_data_o, 32'hFFFF0000);
`else
    check("collision_readfirst", rsp_data_o, 32'hFFFFFFFF);
`endif
    rd(8'd9);
    check("collision_after", rsp_data_o, 32'hFFFF0000);

    // Reset while a response is held; a write during reset must not land
    rreq_valid_i = 1'b0; rsp_ready_i = 1'b0;
    tick();
    #2 arst_i = 1'b1;
    #1;
    check("midreset_valid", CW'(rsp_valid_o), 0);
    check("midreset_data", rsp_data_o, 0);
    m_valid = 1'b0; m_data = '0;
    we_i = 1'b1; waddr_i = 8'd9; wdata_i = 32'h12345678; wstrb_i = 4'hF;
    tick();
    arst_i = 1'b0; we_i = 1'b0;
    check("midreset_ready", CW'(rreq_ready_o), 1);
    rd(8'd9);
    check("no_write_in_reset", rsp_data_o, 32'hFFFF0000);

    // Full-throughput streaming
    for (int i = 0; i < 16; i++) wr(8'(i), CW'(i), 4'hF);
    for (int i = 0; i < 16; i++) begin
      rreq_valid_i = 1'b1; raddr_i = 8'(i); rsp_ready_i = 1'b1;
      tick();
      check("stream_valid", CW'(rsp_valid_o), 1);
      check("stream_data", rsp_data_o, CW'(i));
    end
    rreq_valid_i = 1'b0;

    // Address extremes and a strobe-less write
    wr(8'd255, 32'hCAFE00FF, 4'hF);
    wr(8'd0, 32'h0BADF00D, 4'hF);
    rd(8'd255);
    check("addr255", rsp_data_o, 32'hCAFE00FF);
    rd(8'd0);
    check("addr0", rsp_data_o, 32'h0BADF00D);
    wr(8'd0, 32'hFFFFFFFF, 4'h0);
    rd(8'd0);
    check("strb0_noop", rsp_data_o, 32'h0BADF00D);

    // Randomized traffic over prefilled addresses 0..15
    for (int i = 0; i < 400; i++) begin
      we_i         = 1'($urandom_range(0, 1));
      waddr_i      = 8'($urandom_range(0, 15));
      wdata_i      = $urandom;
      wstrb_i      = 4'($urandom_range(0, 15));
      rreq_valid_i = 1'($urandom_range(0, 1));
      raddr_i      = 8'($urandom_range(0, 15));
      rsp_ready_i  = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
